// File: rtl/bulb_pkg.sv
// Shared encodings and step helpers for the LED chaser sequencer.
package bulb_pkg;

  localparam int TICK_CYC_DEF = 50000000;
  localparam int NUM_BTN      = 4;
  localparam int BTN_RUN      = 0;
  localparam int BTN_STOP     = 1;
  localparam int BTN_MODE     = 2;
  localparam int BTN_SPD      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    PAT_LEFT   = 2'd0,
    PAT_RIGHT  = 2'd1,
    PAT_BOUNCE = 2'd2
  } pat_t;

  // Encoded value is the prescaler right-shift amount.
  typedef enum logic [1:0] {
    SPD_1 = 2'd0,
    SPD_2 = 2'd1,
    SPD_4 = 2'd2
  } spd_t;

  typedef struct packed {
    logic [1:0] pos;
    logic       up;
  } step_t;

  function automatic pat_t pat_next(input pat_t p);
    case (p)
      PAT_LEFT:  return PAT_RIGHT;
      PAT_RIGHT: return PAT_BOUNCE;
      default:   return PAT_LEFT;
    endcase
  endfunction

  function automatic spd_t spd_next(input spd_t s);
    case (s)
      SPD_1:   return SPD_2;
      SPD_2:   return SPD_4;
      default: return SPD_1;
    endcase
  endfunction

  // Bounce reflects at the ends so neither end LED is shown twice in a row.
  function automatic step_t step_pos(input pat_t p, input step_t s);
    step_t r;
    r = s;
    case (p)
      PAT_LEFT:  r.pos = s.pos + 2'd1;
      PAT_RIGHT: r.pos = s.pos - 2'd1;
      default: begin
        if (s.up && s.pos == 2'd3) begin
          r.up  = 1'b0;
          r.pos = 2'd2;
        end else if (!s.up && s.pos == 2'd0) begin
          r.up  = 1'b1;
          r.pos = 2'd1;
        end else begin
          r.pos = s.up ? s.pos + 2'd1 : s.pos - 2'd1;
        end
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bulb_seq_ctrl_if.sv
// Button levels in, LED/state/tick out for the chaser sequencer.
interface bulb_seq_ctrl_if;
  logic       btn_run;
  logic       btn_stop;
  logic       btn_mode;
  logic       btn_spd;
  logic [3:0] ledo;
  logic [1:0] state_o;
  logic       tick_o;

  modport master (
    output btn_run, btn_stop, btn_mode, btn_spd,
    input  ledo, state_o, tick_o
  );

  modport slave (
    input  btn_run, btn_stop, btn_mode, btn_spd,
    output ledo, state_o, tick_o
  );
endinterface

// File: rtl/btn_nedge.sv
// Falling-edge detector for one debounced button level.
module btn_nedge (
  input  logic clk,
  input  logic rset,
  input  logic lvl,
  output logic ev
);
  logic hist;

  // History clears to 0 so a button held low across reset never fires.
  always_ff @(posedge clk or negedge rset) begin
    if (!rset) hist <= 1'b0;
    else       hist <= lvl;
  end

  assign ev = hist & ~lvl;
endmodule

// File: rtl/bulb_seq_ctrl.sv
// Start/pause/stop sequencer with speed prescaler and pattern engine for a 4-LED chaser.
module bulb_seq_ctrl
  import bulb_pkg::*;
#(
  parameter int TICK_CYC = TICK_CYC_DEF,
  parameter int CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rset,
  bulb_seq_ctrl_if.slave  bus
);

  logic [NUM_BTN-1:0] lvl, ev;
  assign lvl = {bus.btn_spd, bus.btn_mode, bus.btn_stop, bus.btn_run};

  btn_nedge u_btn [NUM_BTN-1:0] (
    .clk  (clk),
    .rset (rset),
    .lvl  (lvl),
    .ev   (ev)
  );

  state_t            state, state_d;
  pat_t              pat, pat_d;
  spd_t              spd, spd_d;
  step_t             cur, cur_d;
  logic [CNT_W-1:0]  cnt, cnt_d, period;
  logic              tick;

  assign period = CNT_W'(TICK_CYC) >> spd;

  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      state <= ST_IDLE;
      pat   <= PAT_LEFT;
      spd   <= SPD_1;
      cur   <= '{pos: 2'd0, up: 1'b1};
      cnt   <= '0;
    end else begin
      state <= state_d;
      pat   <= pat_d;
      spd   <= spd_d;
      cur   <= cur_d;
      cnt   <= cnt_d;
    end
  end

  // Stop beats run, and either one swallows mode/speed/tick in that cycle.
  always_comb begin
    state_d = state;
    pat_d   = pat;
    spd_d   = spd;
    cur_d   = cur;
    cnt_d   = cnt;
    tick    = 1'b0;
    if (ev[BTN_STOP]) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (ev[BTN_RUN]) begin
      cnt_d = '0;
      case (state)
        ST_IDLE: begin
          state_d   = ST_RUN;
          cur_d.pos = (pat == PAT_RIGHT) ? 2'd3 : 2'd0;
          cur_d.up  = (pat != PAT_RIGHT);
        end
        ST_RUN:  state_d = ST_PAUSE;
        default: state_d = ST_RUN;
      endcase
    end else begin
      if (state == ST_RUN) begin
        if (cnt == period - 1'b1) begin
          tick  = 1'b1;
          cnt_d = '0;
          cur_d = step_pos(pat, cur);
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
      if (ev[BTN_SPD]) begin
        spd_d = spd_next(spd);
        cnt_d = '0;
      end
      // Step above used the old pattern; direction forcing lands on top of it.
      if (ev[BTN_MODE]) begin
        pat_d = pat_next(pat);
        if (state != ST_IDLE) begin
          case (pat_d)
            PAT_LEFT:  cur_d.up = 1'b1;
            PAT_RIGHT: cur_d.up = 1'b0;
            default:   cur_d.up = cur_d.up;
          endcase
        end
      end
    end
  end

  assign bus.ledo    = (state == ST_IDLE) ? 4'b0000 : (4'b0001 << cur.pos);
  assign bus.state_o = state;
  assign bus.tick_o  = tick;

endmodule

// File: tb/tb_bulb_seq_ctrl.sv
// Directed bench for bulb_seq_ctrl with an 8-cycle base step period.
module tb_bulb_seq_ctrl;

  logic clk = 1'b0;
  logic rset;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n;
  int   bad_tick, bad_led;

  bulb_seq_ctrl_if bus ();

  bulb_seq_ctrl #(.TICK_CYC(8), .CNT_W(32)) dut (
    .clk  (clk),
    .rset (rset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Mask order {spd, mode, stop, run}; level low for one cycle then released.
  task automatic press(input logic [3:0] m);
    if (m[0]) bus.btn_run  = 1'b0;
    if (m[1]) bus.btn_stop = 1'b0;
    if (m[2]) bus.btn_mode = 1'b0;
    if (m[3]) bus.btn_spd  = 1'b0;
    cyc(1);
    bus.btn_run  = 1'b1;
    bus.btn_stop = 1'b1;
    bus.btn_mode = 1'b1;
    bus.btn_spd  = 1'b1;
  endtask

  task automatic wait_tick(input int max, output int cnt);
    cnt = 0;
    while (bus.tick_o !== 1'b1 && cnt < max) begin
      cyc(1);
      cnt++;
    end
    if (bus.tick_o !== 1'b1) cnt = -1;
  endtask

  task automatic expect_step(input string tag, input int exp_n, input logic [3:0] exp_led);
    int w;
    wait_tick(exp_n + 4, w);
    chk({tag, "_gap"}, w, exp_n);
    cyc(1);
    chk({tag, "_led"}, bus.ledo, exp_led);
    chk({tag, "_tick_lo"}, bus.tick_o, 1'b0);
  endtask

  initial begin
    rset = 1'b0;
    bus.btn_run = 1'b1; bus.btn_stop = 1'b1; bus.btn_mode = 1'b1; bus.btn_spd = 1'b1;
    #23;
    chk("rst_led", bus.ledo, 4'b0000);
    chk("rst_state", bus.state_o, 2'b00);
    chk("rst_tick", bus.tick_o, 1'b0);
    rset = 1'b1;
    cyc(3);

    // Chase-left at base speed
    press(4'b0001);
    chk("run_state", bus.state_o, 2'b01);
    chk("run_led", bus.ledo, 4'b0001);
    expect_step("L1", 7, 4'b0010);
    expect_step("L2", 7, 4'b0100);
    expect_step("L3", 7, 4'b1000);
    expect_step("L4", 7, 4'b0001);

    // Bounce from pos 0
    press(4'b0010);
    chk("stop_state", bus.state_o, 2'b00);
    cyc(1); press(4'b0100);
    cyc(1); press(4'b0100);
    cyc(1); press(4'b0001);
    chk("b_start_led", bus.ledo, 4'b0001);
    expect_step("B1", 7, 4'b0010);
    expect_step("B2", 7, 4'b0100);
    expect_step("B3", 7, 4'b1000);
    expect_step("B4", 7, 4'b0100);
    expect_step("B5", 7, 4'b0010);
    expect_step("B6", 7, 4'b0001);
    expect_step("B7", 7, 4'b0010);

    // Speed cycling in RUN
    press(4'b1000);
    expect_step("S1a", 3, 4'b0100);
    expect_step("S1b", 3, 4'b1000);
    press(4'b1000);
    expect_step("S2a", 1, 4'b0100);
    expect_step("S2b", 1, 4'b0010);
    press(4'b1000);
    expect_step("S0a", 7, 4'b0001);
    expect_step("S0b", 7, 4'b0010);
    expect_step("S0c", 7, 4'b0100);

    // Pause holds position, resume restarts a full period
    press(4'b0001);
    chk("pause_state", bus.state_o, 2'b10);
    chk("pause_led0", bus.ledo, 4'b0100);
    bad_tick = 0; bad_led = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (bus.tick_o !== 1'b0) bad_tick++;
      if (bus.ledo !== 4'b0100) bad_led++;
    end
    chk("pause_no_tick", bad_tick, 0);
    chk("pause_hold_led", bad_led, 0);
    press(4'b0001);
    chk("resume_state", bus.state_o, 2'b01);
    expect_step("R1", 7, 4'b1000);

    // Run and stop together go to IDLE
    press(4'b0011);
    chk("runstop_state", bus.state_o, 2'b00);
    chk("runstop_led", bus.ledo, 4'b0000);
    cyc(1);

    // Tick coinciding with a run press pauses without stepping
    press(4'b0001);
    chk("tc_run_led", bus.ledo, 4'b0001);
    cyc(7);
    chk("tc_tick_pending", bus.tick_o, 1'b1);
    bus.btn_run = 1'b0;
    #1;
    chk("tc_tick_blocked", bus.tick_o, 1'b0);
    cyc(1);
    bus.btn_run = 1'b1;
    chk("tc_state", bus.state_o, 2'b10);
    chk("tc_led", bus.ledo, 4'b0001);

    // Reset mid-RUN with bounce at speed 1
    cyc(1); press(4'b1000);
    cyc(1); press(4'b0001);
    expect_step("M1", 3, 4'b0010);
    expect_step("M2", 3, 4'b0100);
    expect_step("M3", 3, 4'b1000);
    #2;
    rset = 1'b0;
    #1;
    chk("mid_rst_led", bus.ledo, 4'b0000);
    chk("mid_rst_state", bus.state_o, 2'b00);
    chk("mid_rst_tick", bus.tick_o, 1'b0);
    bus.btn_run = 1'b0;
    cyc(2);
    #2;
    rset = 1'b1;
    cyc(3);
    chk("held_low_state", bus.state_o, 2'b00);
    bus.btn_run = 1'b1;
    cyc(3);
    chk("release_state", bus.state_o, 2'b00);
    press(4'b0001);
    chk("post_rst_state", bus.state_o, 2'b01);
    chk("post_rst_led", bus.ledo, 4'b0001);
    expect_step("P1", 7, 4'b0010);
    expect_step("P2", 7, 4'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bulb_seq_ctrl.md
Name: bulb_seq_ctrl

Overview:
Sequencing controller for the 4-LED chaser display. It takes debounced push-button levels, detects press events, and runs a start/pause/stop state machine. A speed-selectable step prescaler and a pattern engine (chase-left, chase-right, bounce) drive the LED outputs. It sits between the debounce instances and the board LEDs, replacing a fixed single-pattern chaser.

Parameters:
TICK_CYC, 50000000, clock cycles per step at speed 0 (1 s at 50 MHz); legal minimum is 8.
CNT_W, 32, prescaler counter width; must hold TICK_CYC-1.

Ports:
clk  input  1  system clock
rset  input  1  asynchronous active-low reset
btn_run  input  1  debounced level; falling edge = press; toggles run/pause
btn_stop  input  1  debounced level; falling edge = press; returns to IDLE
btn_mode  input  1  debounced level; falling edge = press; cycles pattern
btn_spd  input  1  debounced level; falling edge = press; cycles speed
ledo  output  4  one-hot LED drive; 0000 in IDLE
state_o  output  2  current FSM state (00 IDLE, 01 RUN, 10 PAUSE)
tick_o  output  1  one-cycle pulse on every step tick in RUN

Behaviour:
- Clock and reset: single clock clk; rset is asynchronous and active-low. Every register clears immediately on rset low, including mid-RUN.
- Reset values: state IDLE, pattern 0, speed 0, pos 0, dir up, prescaler cnt 0, all button-history flops 0, ledo 0000, state_o 00, tick_o 0.
- Edge detect, per button: a history flop holds the previous level. Event = history & ~current, giving one pulse per press and one cycle of latency after the falling edge. Because history resets to 0, a button held low through reset produces no event.
- Same-cycle priority: stop > run > (mode, spd). Mode and speed events can occur in the same cycle as each other and both take effect.
- Speed:
  - 2-bit register, cycles 0→1→2→0; value 3 is unreachable.
  - Period = TICK_CYC >> speed, i.e. /1, /2, /4.
  - A speed event clears cnt to 0 in any state.
- Prescaler:
  - Counts only in RUN.
  - When cnt == period-1: tick for one cycle and cnt→0; otherwise cnt+1.
  - cnt is held at 0 in IDLE and PAUSE, so a resume restarts a full period.
- FSM:
  - IDLE + run event → RUN. pos is loaded from the pattern: chase-left pos 0, dir up; chase-right pos 3, dir down; bounce pos 0, dir up. The first tick follows a full period after entry.
  - RUN + run event → PAUSE. pos and dir are frozen and ledo keeps showing pos.
  - PAUSE + run event → RUN, continuing from the frozen pos and dir.
  - Stop event in any state → IDLE. Pattern and speed are retained.
- Pattern:
  - 2-bit register: 0 chase-left, 1 chase-right, 2 bounce; cycles 0→1→2→0 on a mode event, in any state.
  - If a change lands in RUN or PAUSE: pos is kept. dir is forced up for chase-left, forced down for chase-right, and kept for bounce.
- Step on tick (mod 4):
  - chase-left: pos+1.
  - chase-right: pos-1.
  - bounce: if dir up and pos 3 → dir down, pos 2. If dir down and pos 0 → dir up, pos 1. Otherwise step in dir.
- Tick coinciding with other events:
  - Tick + run event: pause wins; no step; tick_o still 0 (tick_o only pulses when a step occurs).
  - Tick + stop event: IDLE; no step.
  - Tick + mode event: the step uses the old pattern; the new pattern applies from the next tick, with the dir forcing above applied after the step.
- Outputs:
  - ledo = 0000 in IDLE, else 1<<pos. ledo and state_o are combinational from registered state, with zero latency.
  - tick_o is high exactly in cycles where pos advances.

Decomposition:
- Shared package bulb_pkg holds the state encodings (ST_IDLE, ST_RUN, ST_PAUSE), pattern codes (PAT_LEFT, PAT_RIGHT, PAT_BOUNCE), speed encodings, and the default TICK_CYC.
- One sub-module, btn_nedge (history flop plus falling-edge pulse), is instantiated four times.
- Prescaler, FSM and pattern engine stay in bulb_seq_ctrl.

Test Plan:
- TICK_CYC=8, speed 0. Reset, press run → state_o 01, ledo 0001. Ticks every 8 cycles; ledo 0010, 0100, 1000, 0001; tick_o is a single-cycle pulse each time.
- Bounce from pos 0. Observe ≥7 ticks → ledo 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; no repeat at the ends.
- Speed presses 1 and 2 in RUN → tick spacing 4 then 2 cycles, with cnt restarted at each press. A third press → spacing 8.
- RUN at ledo 0100, press run → PAUSE; ledo holds 0100 for 20 cycles with no tick_o. Press run → the next step occurs a full period after resume.
- Run and stop falling edges in the same cycle while in RUN → IDLE, ledo 0000. A tick coinciding with a run press → PAUSE, pos unchanged.
- Assert rset mid-RUN at ledo 1000 with pattern 2 and speed 1 → immediately ledo 0000, state_o 00. After release, run → ledo 0001 with chase-left at 8-cycle spacing. A button held low through reset produces no event.
